// File: rtl/m10k_write_sram1.sv
// CSR loader for SRAM1: writes the row-pointer word to address 0, then packs a
// stream of 4-bit column indices into four zero-padded 256-bit words at 1..4.
module m10k_write_sram1 (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_write_start,
   input  logic         i_write_reset,
   input  logic [255:0] i_row_ptr,
   input  logic [8:0]   i_nnz,
   input  logic         i_col_valid,
   input  logic [3:0]   i_col_idx,
   output logic         o_col_ready,
   output logic         o_write_en,
   output logic [4:0]   o_write_addr,
   output logic [255:0] o_write_data,
   output logic [3:0]   o_state,
   output logic         o_done
);

   typedef enum logic [3:0] {
      S_WRITE_RP = 4'd0,
      S_FILL     = 4'd1,
      S_WRITE_CI = 4'd2,
      S_DONE     = 4'd6,
      S_IDLE     = 4'd15
   } state_e;

   state_e         state_q, state_d;
   logic [255:0]   rp_buf_q, rp_buf_d;
   logic [255:0]   pack_buf_q, pack_buf_d;
   logic [8:0]     nnz_q, nnz_d;
   logic [8:0]     k_q, k_d;
   logic [1:0]     word_idx_q, word_idx_d;
   logic           accept;

   assign accept = (state_q == S_FILL) && i_col_valid;

   // NOTE: every variable gets its hold value first so no branch can leave one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      rp_buf_d   = rp_buf_q;
      pack_buf_d = pack_buf_q;
      nnz_d      = nnz_q;
      k_d        = k_q;
      word_idx_d = word_idx_q;
      case (state_q)
         S_IDLE: begin
            if (i_write_start) begin
               rp_buf_d   = i_row_ptr;
               nnz_d      = (i_nnz > 9'd256) ? 9'd256 : i_nnz;
               k_d        = '0;
               word_idx_d = '0;
               pack_buf_d = '0;
               state_d    = S_WRITE_RP;
            end
         end
         S_WRITE_RP: begin
            state_d = (nnz_q == 9'd0) ? S_WRITE_CI : S_FILL;
         end
         S_FILL: begin
            if (accept) begin
               pack_buf_d[{k_q[5:0], 2'b00} +: 4] = i_col_idx;
               k_d = k_q + 9'd1;
               // Close the word when it is full or the last entry has arrived.
               if ((k_q[5:0] == 6'd63) || (k_q == nnz_q - 9'd1)) begin
                  state_d = S_WRITE_CI;
               end
            end
         end
         S_WRITE_CI: begin
            if (word_idx_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               word_idx_d = word_idx_q + 2'd1;
               pack_buf_d = '0;
               state_d    = (k_q < nnz_q) ? S_FILL : S_WRITE_CI;
            end
         end
         S_DONE: begin
            if (i_write_reset) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values sampled at the clock edge.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_IDLE;
         rp_buf_q   <= '0;
         pack_buf_q <= '0;
         nnz_q      <= '0;
         k_q        <= '0;
         word_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         rp_buf_q   <= rp_buf_d;
         pack_buf_q <= pack_buf_d;
         nnz_q      <= nnz_d;
         k_q        <= k_d;
         word_idx_q <= word_idx_d;
      end
   end

   always_comb begin
      o_col_ready  = 1'b0;
      o_write_en   = 1'b0;
      o_write_addr = 5'd0;
      o_write_data = '0;
      case (state_q)
         S_WRITE_RP: begin
            o_write_en   = 1'b1;
            o_write_data = rp_buf_q;
         end
         S_FILL: o_col_ready = 1'b1;
         S_WRITE_CI: begin
            o_write_en   = 1'b1;
            o_write_addr = 5'd1 + {3'd0, word_idx_q};
            o_write_data = pack_buf_q;
         end
         default: ;
      endcase
   end

   assign o_state = state_q;
   assign o_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_m10k_write_sram1.sv
// Bench for m10k_write_sram1: loads push expected SRAM1 writes into a queue and
// a negedge monitor pops and compares each write the DUT issues.
module tb_m10k_write_sram1;

   logic         i_clk = 1'b0;
   logic         i_rstn;
   logic         i_write_start;
   logic         i_write_reset;
   logic [255:0] i_row_ptr;
   logic [8:0]   i_nnz;
   logic         i_col_valid;
   logic [3:0]   i_col_idx;
   logic         o_col_ready;
   logic         o_write_en;
   logic [4:0]   o_write_addr;
   logic [255:0] o_write_data;
   logic [3:0]   o_state;
   logic         o_done;

   m10k_write_sram1 dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_write_start (i_write_start),
      .i_write_reset (i_write_reset),
      .i_row_ptr     (i_row_ptr),
      .i_nnz         (i_nnz),
      .i_col_valid   (i_col_valid),
      .i_col_idx     (i_col_idx),
      .o_col_ready   (o_col_ready),
      .o_write_en    (o_write_en),
      .o_write_addr  (o_write_addr),
      .o_write_data  (o_write_data),
      .o_state       (o_state),
      .o_done        (o_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [4:0]   addr;
      logic [255:0] data;
   } wr_t;

   wr_t        sb[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] ent[0:511];

   localparam logic [255:0] PAT_UP   = {4{64'hFEDCBA9876543210}};
   localparam logic [255:0] PAT_DOWN = {4{64'h0123456789ABCDEF}};

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge i_clk) begin
      if (i_rstn && o_write_en) begin
         check("write_expected", 256'(sb.size() != 0), 256'd1);
         if (sb.size() != 0) begin
            wr_t e;
            e = sb.pop_front();
            check("write_addr", 256'(o_write_addr), 256'(e.addr));
            check("write_data", o_write_data, e.data);
         end
      end
   end

   // One load: queue expected writes, start, stream entries from ent[] with
   // valid offered every cycle (optionally with random gaps) until DONE.
   task automatic run_load(input logic [255:0] rp, input logic [8:0] nnz,
                           input logic [255:0] w1, input logic [255:0] w2,
                           input logic [255:0] w3, input logic [255:0] w4,
                           input bit gaps, input int abort_at, input int pulse_at,
                           output int acc, output int cyc, output bit ready_seen);
      bit done_seen = 0;
      bit accept;
      sb.push_back('{5'd0, rp});
      if (abort_at < 0) begin
         sb.push_back('{5'd1, w1});
         sb.push_back('{5'd2, w2});
         sb.push_back('{5'd3, w3});
         sb.push_back('{5'd4, w4});
      end
      acc = 0;
      ready_seen = 0;
      @(negedge i_clk);
      i_row_ptr = rp;
      i_nnz = nnz;
      i_write_start = 1'b1;
      @(posedge i_clk);
      cyc = 1;
      for (int t = 0; t < 3000; t++) begin
         @(negedge i_clk);
         i_write_start = (t == pulse_at);
         i_write_reset = (t == pulse_at);
         i_row_ptr = ~rp;
         i_nnz = 9'd3;
         if (o_done) begin
            done_seen = 1;
            break;
         end
         if (abort_at >= 0 && acc == abort_at) begin
            i_col_valid = 1'b0;
            i_rstn = 1'b0;
            #1;
            check("abort_state", 256'(o_state), 256'd15);
            check("abort_ready", 256'(o_col_ready), 256'd0);
            check("abort_wen", 256'(o_write_en), 256'd0);
            check("abort_wdata", o_write_data, 256'd0);
            check("abort_no_pending", 256'(sb.size()), 256'd0);
            @(negedge i_clk);
            i_rstn = 1'b1;
            break;
         end
         i_col_valid = !gaps || ($urandom_range(0, 2) != 0);
         i_col_idx = ent[acc];
         if (o_col_ready) ready_seen = 1;
         accept = i_col_valid && o_col_ready;
         @(posedge i_clk);
         cyc++;
         if (accept) acc++;
      end
      i_col_valid = 1'b0;
      i_write_start = 1'b0;
      i_write_reset = 1'b0;
      if (abort_at < 0) begin
         check("load_reached_done", 256'(done_seen), 256'd1);
         check("all_writes_seen", 256'(sb.size()), 256'd0);
         @(negedge i_clk);
         i_write_reset = 1'b1;
         @(posedge i_clk);
         @(negedge i_clk);
         i_write_reset = 1'b0;
         check("back_to_idle", 256'(o_state), 256'd15);
         check("done_cleared", 256'(o_done), 256'd0);
      end
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  acc, cyc;
      bit  rs;
      i_rstn = 1'b0;
      i_write_start = 1'b0;
      i_write_reset = 1'b0;
      i_row_ptr = '0;
      i_nnz = '0;
      i_col_valid = 1'b0;
      i_col_idx = '0;
      #12;
      check("rst_state", 256'(o_state), 256'd15);
      check("rst_ready", 256'(o_col_ready), 256'd0);
      check("rst_wen", 256'(o_write_en), 256'd0);
      check("rst_waddr", 256'(o_write_addr), 256'd0);
      check("rst_wdata", o_write_data, 256'd0);
      check("rst_done", 256'(o_done), 256'd0);
      @(negedge i_clk);
      i_rstn = 1'b1;

      // Full load, valid always high.
      for (int i = 0; i < 512; i++) ent[i] = 4'(i % 16);
      run_load({8{32'hA5A5_0001}}, 9'd256, PAT_UP, PAT_UP, PAT_UP, PAT_UP, 0, -1, -1, acc, cyc, rs);
      check("full_accepted", 256'(acc), 256'd256);
      check("full_cycles", 256'(cyc), 256'd262);

      // Five entries; extra offered entries must be refused.
      for (int i = 0; i < 512; i++) ent[i] = 4'hF;
      for (int i = 0; i < 5; i++) ent[i] = 4'(i + 1);
      run_load({8{32'h1234_5678}}, 9'd5, 256'h54321, 256'd0, 256'd0, 256'd0, 0, -1, -1, acc, cyc, rs);
      check("five_accepted", 256'(acc), 256'd5);

      // Empty load: five back-to-back writes, ready never raised.
      run_load({4{64'hDEAD_BEEF_CAFE_F00D}}, 9'd0, 256'd0, 256'd0, 256'd0, 256'd0, 0, -1, -1, acc, cyc, rs);
      check("zero_accepted", 256'(acc), 256'd0);
      check("zero_cycles", 256'(cyc), 256'd6);
      check("zero_ready_never", 256'(rs), 256'd0);

      // One full word with random valid gaps.
      for (int i = 0; i < 512; i++) ent[i] = 4'hA;
      for (int i = 0; i < 64; i++) ent[i] = 4'(15 - (i % 16));
      run_load({8{32'h0F0F_0F0F}}, 9'd64, PAT_DOWN, 256'd0, 256'd0, 256'd0, 1, -1, -1, acc, cyc, rs);
      check("gaps_accepted", 256'(acc), 256'd64);

      // Reset at k=30, then a clamped load of 300 entries.
      for (int i = 0; i < 512; i++) ent[i] = 4'(i % 16);
      run_load({8{32'h7777_0000}}, 9'd100, 256'd0, 256'd0, 256'd0, 256'd0, 0, 30, -1, acc, cyc, rs);
      check("abort_accepted", 256'(acc), 256'd30);
      run_load({8{32'h3C3C_C3C3}}, 9'd300, PAT_UP, PAT_UP, PAT_UP, PAT_UP, 0, -1, -1, acc, cyc, rs);
      check("clamp_accepted", 256'(acc), 256'd256);
      check("clamp_cycles", 256'(cyc), 256'd262);

      // Start and reset pulsed mid-FILL are ignored.
      run_load({8{32'h0BAD_F00D}}, 9'd256, PAT_UP, PAT_UP, PAT_UP, PAT_UP, 0, -1, 10, acc, cyc, rs);
      check("pulse_accepted", 256'(acc), 256'd256);
      check("pulse_cycles", 256'(cyc), 256'd262);

      repeat (3) @(negedge i_clk);
      check("final_idle", 256'(o_state), 256'd15);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/m10k_write_sram1.md
# m10k_write_sram1

CSR loader that fills SRAM1 (M10K, 256-bit words, 5-bit address) with one row-pointer word and four column-index words. It sits between the host-side matrix input path and the SRAM1 write port, and produces the layout the SRAM1 reader consumes:
- address 0: row_ptr word
- addresses 1..4: col_idx words, 64 four-bit entries each; entry k at word 1+k/64, bits (k%64)*4 +: 4

Column indices arrive as a valid/ready stream of 4-bit values. They are packed, zero-padded, and always written as exactly five words.

## Interface
Parameters: none.
- i_clk  input  1  clock; all state changes on rising edge
- i_rstn  input  1  asynchronous, active-low reset
- i_write_start  input  1  start a load; sampled only in IDLE
- i_write_reset  input  1  leave DONE; sampled only in DONE
- i_row_ptr  input  256  row-pointer word; captured in IDLE when i_write_start=1
- i_nnz  input  9  number of col_idx entries; captured with i_row_ptr; values above 256 clamp to 256
- i_col_valid  input  1  i_col_idx is valid
- i_col_idx  input  4  column-index entry
- o_col_ready  output  1  block accepts an entry this cycle
- o_write_en  output  1  SRAM1 write strobe
- o_write_addr  output  5  SRAM1 write address
- o_write_data  output  256  SRAM1 write data
- o_state  output  4  current state code
- o_done  output  1  high while in DONE

## Operation
State codes: IDLE=15, WRITE_RP=0, FILL=1, WRITE_CI=2, DONE=6. Any other code returns to IDLE.

Registers:
- rp_buf[255:0] and pack_buf[255:0]
- nnz_r[8:0]
- k[8:0]: entries accepted
- word_idx[1:0]

Transitions:
- IDLE, i_write_start=1: capture rp_buf<=i_row_ptr and nnz_r<=min(i_nnz,256). Clear k, word_idx and pack_buf. Go to WRITE_RP.
- WRITE_RP: go to WRITE_CI if nnz_r==0, else to FILL.
- FILL, on accept (i_col_valid & o_col_ready): write pack_buf[(k%64)*4 +: 4]<=i_col_idx, then k<=k+1.
  - If the accepted entry has k%64==63 or k==nnz_r-1, go to WRITE_CI.
  - Otherwise stay in FILL.
- WRITE_CI: the current pack_buf is written.
  - If word_idx==3, go to DONE.
  - Otherwise word_idx<=word_idx+1 and pack_buf<=0. Go to FILL if k<nnz_r, else to WRITE_CI (zero-pad word).
- DONE: go to IDLE if i_write_reset=1, else stay in DONE.

Outputs (combinational from state and registers):
- o_col_ready = (state==FILL).
- o_write_en = (state==WRITE_RP) | (state==WRITE_CI).
- o_write_addr: 0 in WRITE_RP; 1+word_idx in WRITE_CI; 0 in all other states.
- o_write_data: rp_buf in WRITE_RP; pack_buf in WRITE_CI; 0 in all other states.
- o_state = state; o_done = (state==DONE).

Rules:
- Every load writes exactly five words, in order: addr 0,1,2,3,4. Each address is written once.
- Unfilled nibbles are always 0.
- Entries offered outside FILL are not accepted (ready=0). Extra entries beyond nnz_r are never accepted.
- i_write_start outside IDLE is ignored. i_write_reset outside DONE is ignored.
- Input values i_row_ptr and i_nnz may change after capture without effect.

## Timing
- Reset (async assert): state=IDLE. All buffers, counters and word_idx are 0. Outputs: o_col_ready=0, o_write_en=0, o_write_addr=0, o_write_data=0, o_done=0, o_state=15.
- Reset mid-load aborts immediately. No further writes are issued. A new load requires a fresh i_write_start.
- WRITE_RP is entered 1 cycle after i_write_start is sampled in IDLE. The write to addr 0 occurs in that cycle.
- Each accepted entry costs 1 cycle. Each col_idx word write costs 1 cycle, during which ready=0.
- With i_col_valid held high:
  - nnz=256: WRITE_RP at cycle 1; DONE at cycle 1+1+4*65=262 after start.
  - nnz=0: five consecutive write cycles, then DONE.
- Gaps in i_col_valid stall in FILL without side effects.

## Test plan
- nnz=256, entries k%16 streamed with valid always high. Expect writes addr0=row_ptr, then addr1..4 each =0xFEDC...3210 pattern. o_done is asserted 262 cycles after start.
- nnz=5, entries 1,2,3,4,5. Expect addr1 data=0x54321 with upper bits 0, and addr2..4=0. After accepting 5 entries, ready stays 0 while valid is held high.
- nnz=0. Expect five back-to-back writes: addr0=row_ptr, addr1..4=0. o_col_ready never asserted. Then i_write_reset returns to IDLE.
- nnz=64, random valid gaps. Expect addr1 fully packed in the correct nibble order and addr2..4 zero. Stalls add cycles but produce no extra writes.
- i_rstn pulsed low mid-FILL (k=30). Expect outputs to zero at once and state=15. Afterwards, i_write_start with nnz=300 clamps to 256: exactly 256 entries accepted.
- i_write_start pulsed during FILL and i_write_reset pulsed during FILL are both ignored. Write sequence and final DONE are unchanged.
